sn_display: RTL and testbench

- Consumer end of the four-digit scrolling-message interface.
- A message source presents frames of four 5-bit symbol codes (sn1..sn4) with a valid/ready handshake. This block accepts one frame and holds it on the four DE0 seven-segment displays for a fixed dwell time, then requests the next frame.
- Decodes symbol codes to active-low segment patterns, with per-digit blink and decimal-point control.
- Sits between the message generator and the HEX0..HEX3 board pins.

---
 rtl/sn_pkg.sv | 40 ++++
 rtl/sn_seg_decode.sv | 25 ++
 rtl/sn_display.sv | 158 +++++++++++++++
 tb/tb_sn_display.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_pkg.sv
// Shared symbol codes, segment patterns and dwell-control state type for the
// four-digit scrolling-message display.
package sn_pkg;

  localparam int unsigned SYM_W = 5;

  localparam logic [SYM_W-1:0] SYM_BLANK = 5'd16;
  localparam logic [SYM_W-1:0] SYM_DASH  = 5'd17;
  localparam logic [SYM_W-1:0] SYM_H     = 5'd18;
  localparam logic [SYM_W-1:0] SYM_L     = 5'd19;
  localparam logic [SYM_W-1:0] SYM_P     = 5'd20;
  localparam logic [SYM_W-1:0] SYM_U     = 5'd21;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_U     = 7'b1000001;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_READY,
    ST_DWELL
  } dwell_state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sn_seg_decode.sv
// Combinational symbol-code to active-low seven-segment pattern decoder.
module sn_seg_decode
  import sn_pkg::*;
(
  input  logic [SYM_W-1:0] i_code,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_code < 5'd16) begin
      o_seg = SEG_HEX[i_code[3:0]];
    end else begin
      unique case (i_code)
        SYM_DASH: o_seg = SEG_DASH;
        SYM_H:    o_seg = SEG_H;
        SYM_L:    o_seg = SEG_L;
        SYM_P:    o_seg = SEG_P;
        SYM_U:    o_seg = SEG_U;
        default:  o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sn_display.sv
// Four-digit frame consumer: accepts a frame on valid/ready, holds it for a
// dwell period, and drives registered, blink-gated segment outputs.
module sn_display
  import sn_pkg::*;
#(
  parameter int unsigned DWELL      = 25000000,
  parameter int unsigned BLINK_HALF = 12500000
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic [SYM_W-1:0] iSN1,
  input  logic [SYM_W-1:0] iSN2,
  input  logic [SYM_W-1:0] iSN3,
  input  logic [SYM_W-1:0] iSN4,
  input  logic [3:0]       iDP,
  input  logic             iHOLD,
  input  logic [3:0]       iBLINK,
  output logic [6:0]       oHEX3_D,
  output logic [6:0]       oHEX2_D,
  output logic [6:0]       oHEX1_D,
  output logic [6:0]       oHEX0_D,
  output logic             oHEX3_DP,
  output logic             oHEX2_DP,
  output logic             oHEX1_DP,
  output logic             oHEX0_DP
);

  localparam int unsigned DW = $clog2(DWELL + 1);
  localparam int unsigned BW = cnt_width(BLINK_HALF);
  localparam logic [DW-1:0] DWELL_LD   = DW'(DWELL);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  dwell_state_t     r_state;
  dwell_state_t     w_state_nx;
  logic [DW-1:0]    r_dwell;
  logic [DW-1:0]    w_dwell_nx;
  logic             w_accept;

  logic [SYM_W-1:0] r_win [4];
  logic [3:0]       r_dp_lat;

  logic [BW-1:0]    r_bcnt;
  logic             r_phase;
  logic [3:0]       w_blank;

  logic [6:0]       w_seg [4];
  logic [6:0]       r_hex [4];
  logic [3:0]       r_dp_n;

  assign oREADY   = (r_state == ST_READY);
  assign w_accept = iVALID && (r_state == ST_READY);

  // ST_READY is the only state with oREADY high; ST_WAIT covers "counter at
  // zero but not ready" (just out of reset, or held while idle).
  always_comb begin
    w_state_nx = r_state;
    w_dwell_nx = r_dwell;
    unique case (r_state)
      ST_READY: begin
        if (iVALID) begin
          w_state_nx = ST_DWELL;
          w_dwell_nx = DWELL_LD;
        end else if (iHOLD) begin
          w_state_nx = ST_WAIT;
        end
      end
      ST_DWELL: begin
        if (!iHOLD) begin
          w_dwell_nx = r_dwell - 1'b1;
          if (r_dwell == DW'(1)) begin
            w_state_nx = ST_READY;
          end
        end
      end
      ST_WAIT: begin
        if (!iHOLD) begin
          w_state_nx = ST_READY;
        end
      end
      default: begin
        w_state_nx = ST_WAIT;
        w_dwell_nx = '0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_WAIT;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dwell <= w_dwell_nx;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned n = 0; n < 4; n++) begin
        r_win[n] <= SYM_BLANK;
      end
      r_dp_lat <= '0;
    end else if (w_accept) begin
      r_win[3] <= iSN1;
      r_win[2] <= iSN2;
      r_win[1] <= iSN3;
      r_win[0] <= iSN4;
      r_dp_lat <= iDP;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == BLINK_LAST) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec
    sn_seg_decode u_dec (
      .i_code (r_win[g]),
      .o_seg  (w_seg[g])
    );
  end

  assign w_blank = {4{r_phase}} & iBLINK;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned n = 0; n < 4; n++) begin
        r_hex[n] <= '1;
      end
      r_dp_n <= '1;
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        r_hex[n]  <= w_blank[n] ? SEG_BLANK : w_seg[n];
        r_dp_n[n] <= w_blank[n] | ~r_dp_lat[n];
      end
    end
  end

  assign oHEX3_D  = r_hex[3];
  assign oHEX2_D  = r_hex[2];
  assign oHEX1_D  = r_hex[1];
  assign oHEX0_D  = r_hex[0];
  assign oHEX3_DP = r_dp_n[3];
  assign oHEX2_DP = r_dp_n[2];
  assign oHEX1_DP = r_dp_n[1];
  assign oHEX0_DP = r_dp_n[0];

endmodule

// File: tb/tb_sn_display.sv
// Self-checking bench for sn_display: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural reference model.
module tb_sn_display;

  localparam int unsigned DW_T = 4;
  localparam int unsigned BH_T = 3;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iVALID;
  logic       oREADY;
  logic [4:0] iSN1, iSN2, iSN3, iSN4;
  logic [3:0] iDP;
  logic       iHOLD;
  logic [3:0] iBLINK;
  logic [6:0] oHEX3_D, oHEX2_D, oHEX1_D, oHEX0_D;
  logic       oHEX3_DP, oHEX2_DP, oHEX1_DP, oHEX0_DP;

  always #5 iCLK = ~iCLK;

  sn_display #(
    .DWELL      (DW_T),
    .BLINK_HALF (BH_T)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iVALID   (iVALID),
    .oREADY   (oREADY),
    .iSN1     (iSN1),
    .iSN2     (iSN2),
    .iSN3     (iSN3),
    .iSN4     (iSN4),
    .iDP      (iDP),
    .iHOLD    (iHOLD),
    .iBLINK   (iBLINK),
    .oHEX3_D  (oHEX3_D),
    .oHEX2_D  (oHEX2_D),
    .oHEX1_D  (oHEX1_D),
    .oHEX0_D  (oHEX0_D),
    .oHEX3_DP (oHEX3_DP),
    .oHEX2_DP (oHEX2_DP),
    .oHEX1_DP (oHEX1_DP),
    .oHEX0_DP (oHEX0_DP)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int unsigned c);
    case (c)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  15: return 7'b0001110;
      17: return 7'b0111111;  18: return 7'b0001001;
      19: return 7'b1000111;  20: return 7'b0001100;
      21: return 7'b1000001;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: displayed frame, cycles of dwell still owed, elapsed
  // cycles since reset (blink phase = elapsed / BLINK_HALF, parity).
  int unsigned m_win [4];
  logic [3:0]  m_dp;
  logic        m_ready;
  int          m_left;
  int          m_tick;
  bit          m_init = 0;
  logic [6:0]  e_hex [4];
  logic [3:0]  e_dp;

  always @(posedge iCLK) begin
    if (iRST) begin
      for (int n = 0; n < 4; n++) begin
        m_win[n] = 16;
        e_hex[n] = 7'h7F;
      end
      m_dp    = 4'h0;
      e_dp    = 4'hF;
      m_ready = 1'b0;
      m_left  = 0;
      m_tick  = 0;
      m_init  = 1;
    end else begin
      bit phase;
      phase = ((m_tick / BH_T) % 2) == 1;
      for (int n = 0; n < 4; n++) begin
        if (phase && iBLINK[n]) begin
          e_hex[n] = 7'h7F;
          e_dp[n]  = 1'b1;
        end else begin
          e_hex[n] = seg_of(m_win[n]);
          e_dp[n]  = ~m_dp[n];
        end
      end
      if (iVALID && m_ready) begin
        m_win[3] = iSN1;
        m_win[2] = iSN2;
        m_win[1] = iSN3;
        m_win[0] = iSN4;
        m_dp     = iDP;
        m_left   = DW_T;
        m_ready  = 1'b0;
      end else if (iHOLD) begin
        m_ready = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        m_ready = (m_left == 0);
      end else begin
        m_ready = 1'b1;
      end
      m_tick++;
    end
  end

  always @(negedge iCLK) begin
    if (m_init) begin
      logic [6:0] a_hex [4];
      logic [3:0] a_dp;
      a_hex[3] = oHEX3_D; a_hex[2] = oHEX2_D; a_hex[1] = oHEX1_D; a_hex[0] = oHEX0_D;
      a_dp = {oHEX3_DP, oHEX2_DP, oHEX1_DP, oHEX0_DP};
      chk("ready", 32'(oREADY), 32'(m_ready));
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("hex%0d", n), 32'(a_hex[n]), 32'(e_hex[n]));
      end
      chk("dp", 32'(a_dp), 32'(e_dp));
    end
  end

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int c;
    for (c = 0; c < 40; c++) begin
      if (oREADY) break;
      step();
    end
    if (c == 40) chk(name, 32'(oREADY), 32'd1);
  endtask

  task automatic send(input int unsigned a, input int unsigned b, input int unsigned c,
                      input int unsigned d, input logic [3:0] dp);
    iSN1 = 5'(a); iSN2 = 5'(b); iSN3 = 5'(c); iSN4 = 5'(d); iDP = dp;
    iVALID = 1'b1;
    step();
    iVALID = 1'b0;
  endtask

  initial begin
    int low;
    int idx;
    int last;
    int changes;
    int last_change;
    logic [6:0] prev;
    logic r;
    int unsigned pat [4];

    iRST = 1'b1; iVALID = 1'b0; iHOLD = 1'b0; iBLINK = 4'h0; iDP = 4'h0;
    iSN1 = 5'd16; iSN2 = 5'd16; iSN3 = 5'd16; iSN4 = 5'd16;

    repeat (3) begin
      step();
      chk("rst_hex", 32'({oHEX3_D, oHEX2_D, oHEX1_D, oHEX0_D}), 32'h0FFF_FFFF);
      chk("rst_dp", 32'({oHEX3_DP, oHEX2_DP, oHEX1_DP, oHEX0_DP}), 32'hF);
      chk("rst_ready", 32'(oREADY), 32'd0);
    end
    iRST = 1'b0;
    step();
    chk("rel_ready", 32'(oREADY), 32'd1);

    // Single frame {4,0,6,4}
    send(4, 0, 6, 4, 4'h0);
    chk("acc_ready", 32'(oREADY), 32'd0);
    step();
    chk("sf_hex3", 32'(oHEX3_D), 32'(7'b0011001));
    chk("sf_hex2", 32'(oHEX2_D), 32'(7'b1000000));
    chk("sf_hex1", 32'(oHEX1_D), 32'(7'b0000010));
    chk("sf_hex0", 32'(oHEX0_D), 32'(7'b0011001));
    low = 1;
    for (int c = 0; c < 20; c++) begin
      if (oREADY) break;
      low++;
      step();
    end
    chk("sf_low", 32'(low), 32'(DW_T));

    // Back-to-back with iVALID held
    pat = '{4, 0, 6, 4};
    idx = 0;
    last = -1;
    iVALID = 1'b1;
    for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
      iSN1 = 5'(pat[idx % 4]);
      iSN2 = 5'(pat[(idx + 1) % 4]);
      iSN3 = 5'(pat[(idx + 2) % 4]);
      iSN4 = 5'(pat[(idx + 3) % 4]);
      r = oREADY;
      step();
      if (r) begin
        if (idx > 0) chk("b2b_gap", 32'(cyc - last), 32'(DW_T + 1));
        last = cyc;
        idx++;
      end
    end
    iVALID = 1'b0;
    chk("b2b_count", 32'(idx), 32'd6);

    // Hold mid-dwell: 2 cycles elapsed, then 10 held cycles
    wait_ready("hold_wait");
    send(1, 2, 3, 5, 4'h0);
    step();
    step();
    iHOLD = 1'b1;
    low = 0;
    for (int c = 0; c < 40; c++) begin
      if (oREADY) break;
      low++;
      if (c == 10) iHOLD = 1'b0;
      step();
    end
    iHOLD = 1'b0;
    chk("hold_low", 32'(low), 32'd12);

    // Decode sweep on the rightmost digit
    for (int unsigned code = 0; code < 32; code++) begin
      wait_ready("dec_wait");
      send(16, 16, 16, code, 4'h0);
      step();
      chk($sformatf("dec%0d", code), 32'(oHEX0_D), 32'(seg_of(code)));
    end

    // Blink on HEX0 with digit 8 and its DP lit
    wait_ready("blink_wait");
    iBLINK = 4'b0001;
    send(16, 16, 16, 8, 4'b0001);
    step();
    prev = oHEX0_D;
    changes = 0;
    last_change = -1;
    for (int c = 0; c < 24; c++) begin
      step();
      chk("blink_val", 32'((oHEX0_D == 7'h00 && !oHEX0_DP) || (oHEX0_D == 7'h7F && oHEX0_DP)), 32'd1);
      chk("blink_other", 32'({oHEX3_D, oHEX2_D, oHEX1_D}), 32'h1F_FFFF);
      if (oHEX0_D != prev) begin
        if (last_change >= 0) chk("blink_period", 32'(c - last_change), 32'(BH_T));
        last_change = c;
        changes++;
      end
      prev = oHEX0_D;
    end
    chk("blink_toggles", 32'(changes), 32'd8);
    iBLINK = 4'h0;

    // Randomized traffic, including occasional resets mid-dwell/mid-blink
    for (int c = 0; c < 3000; c++) begin
      iRST   = ($urandom_range(0, 199) == 0);
      iVALID = ($urandom_range(0, 2) != 0);
      iHOLD  = ($urandom_range(0, 9) == 0);
      iBLINK = 4'($urandom);
      iDP    = 4'($urandom);
      iSN1   = 5'($urandom_range(0, 31));
      iSN2   = 5'($urandom_range(0, 31));
      iSN3   = 5'($urandom_range(0, 31));
      iSN4   = 5'($urandom_range(0, 31));
      step();
    end
    iRST = 1'b0; iVALID = 1'b0; iHOLD = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
